instr_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the PC stage.
- Takes the current PC and issues it as a request on the instruction bus.
- Returns the advance enable (i_PcEn) to the PC stage.
- Buffers in-order responses together with their PCs and presents {instr, pc} to decode.
- On a taken branch/jump from the M stage, discards all younger in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the instruction-fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Counter width able to hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with async reset and synchronous clear
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always @(posedge clk) begin
        assert (!(push && full && !pop));
        assert (!(pop && empty));
    end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: issues PC on the i-bus, tracks in-flight reads, buffers for decode
module instr_fetch #(
    parameter int DEPTH = 2,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic [XLEN-1:0] i_Pc,
    input  logic            i_Flush,
    output logic            o_PcEn,
    output logic            o_IBusReq,
    output logic [XLEN-1:0] o_IBusAddr,
    input  logic            i_IBusGnt,
    input  logic            i_IBusRValid,
    input  logic [XLEN-1:0] i_IBusRData,
    output logic            o_Valid_D,
    output logic [XLEN-1:0] o_Instr_D,
    output logic [XLEN-1:0] o_Pc_D,
    input  logic            i_Stall_D
);
    localparam int CW = fetch_pkg::cnt_w(DEPTH);

    logic [CW-1:0]     inflight;
    logic [CW-1:0]     kill;
    logic [CW-1:0]     pcq_count;
    logic [CW-1:0]     ibuf_count;
    logic [CW:0]       occupancy;
    logic              credit;
    logic              grant;
    logic              rsp;
    logic              ibuf_push;
    logic              ibuf_pop;
    logic              pcq_full;
    logic              pcq_empty;
    logic              ibuf_full;
    logic              ibuf_empty;
    logic [XLEN-1:0]   pcq_head;
    logic [2*XLEN-1:0] ibuf_head;

    // Every outstanding read owns an ibuf slot, so the buffer can never overflow
    assign occupancy  = {1'b0, inflight} + {1'b0, ibuf_count};
    assign credit     = occupancy < (CW+1)'(DEPTH);
    assign o_IBusReq  = ~i_Rst & credit & ~i_Flush;
    assign o_IBusAddr = i_Pc;
    assign grant      = o_IBusReq & i_IBusGnt;
    assign o_PcEn     = ~i_Rst & (grant | i_Flush);

    assign rsp        = i_IBusRValid & (inflight != '0);
    assign ibuf_push  = rsp & (kill == '0) & ~i_Flush;
    assign o_Valid_D  = ~ibuf_empty & ~i_Flush;
    assign ibuf_pop   = o_Valid_D & ~i_Stall_D;

    assign o_Pc_D     = o_Valid_D ? ibuf_head[2*XLEN-1:XLEN] : '0;
    assign o_Instr_D  = o_Valid_D ? ibuf_head[XLEN-1:0]
                                  : (i_Rst ? '0 : XLEN'(fetch_pkg::NOP));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(rsp);
            // A redirect condemns every read still outstanding after this cycle
            if (i_Flush)
                kill <= inflight - CW'(rsp);
            else if (rsp && (kill != '0))
                kill <= kill - CW'(1);
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcq (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .clr   (1'b0),
        .push  (grant),
        .wdata (i_Pc),
        .pop   (rsp),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ibuf (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .clr   (i_Flush),
        .push  (ibuf_push),
        .wdata ({pcq_head, i_IBusRData}),
        .pop   (ibuf_pop),
        .rdata (ibuf_head),
        .full  (ibuf_full),
        .empty (ibuf_empty),
        .count (ibuf_count)
    );

    always @(posedge i_Clk) begin
        assert (kill <= inflight);
        assert (pcq_count == inflight);
        assert (!(grant && pcq_full));
        assert (!(rsp && pcq_empty));
        assert (!(ibuf_push && ibuf_full));
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        pc_en;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc_d;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] reqq[$];
    logic        granted = 1'b0;
    int          ngrant = 0;
    logic [31:0] tgt_cur = '0;

    bit          t1_v  [9] = '{0, 0, 1, 1, 0, 1, 1, 0, 1};
    logic [31:0] t1_pc [9] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(2), .XLEN(32)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Pc         (pc),
        .i_Flush      (flush),
        .o_PcEn       (pc_en),
        .o_IBusReq    (req),
        .o_IBusAddr   (addr),
        .i_IBusGnt    (gnt),
        .i_IBusRValid (rvalid),
        .i_IBusRData  (rdata),
        .o_Valid_D    (valid),
        .o_Instr_D    (instr),
        .o_Pc_D       (pc_d),
        .i_Stall_D    (stall)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Apply this cycle's inputs; the bus returns the tagged word of the oldest request
    task automatic drive(input logic g, input logic r, input logic f, input logic [31:0] t, input logic s);
        gnt     = g;
        rvalid  = r;
        flush   = f;
        stall   = s;
        tgt_cur = t;
        rdata   = (reqq.size() > 0) ? tag(reqq[0]) : 32'hDEAD_BEEF;
        #1;
    endtask

    // Bus bookkeeping, clock edge, then the PC-stage model
    task automatic adv();
        logic en;
        en      = pc_en;
        granted = req & gnt;
        if (rvalid && reqq.size() > 0) void'(reqq.pop_front());
        if (granted) begin
            reqq.push_back(addr);
            ngrant++;
        end
        @(posedge clk);
        #1;
        if (en) pc = flush ? tgt_cur : pc + 32'd4;
    endtask

    task automatic do_reset(input logic [31:0] start);
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; flush = 1'b0; stall = 1'b0; rdata = '0;
        reqq.delete();
        granted = 1'b0;
        ngrant  = 0;
        pc      = start;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b1; gnt = 1'b1; rvalid = 1'b0; stall = 1'b0;
        pc = 32'h40; rdata = '0;
        #2;
        chk("rst_req",   32'(req),   32'h0);
        chk("rst_pcen",  32'(pc_en), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instr,      32'h0);
        chk("rst_pcd",   pc_d,       32'h0);

        // Streaming with one-cycle responses
        do_reset(32'h0);
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
            if (c == 0) begin
                chk("t1_req0",  32'(req),   32'h1);
                chk("t1_pcen0", 32'(pc_en), 32'h1);
                chk("t1_addr0", addr,       32'h0);
            end
            chk($sformatf("t1_valid_c%0d", c), 32'(valid), 32'(t1_v[c]));
            if (t1_v[c]) begin
                chk($sformatf("t1_pc_c%0d", c),    pc_d,  t1_pc[c]);
                chk($sformatf("t1_instr_c%0d", c), instr, tag(t1_pc[c]));
            end
            adv();
        end

        // Decode stall saturates the credit
        do_reset(32'h0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, granted, 1'b0, 32'h0, 1'b1);
            if (c == 9) begin
                chk("t2_req_stalled",  32'(req),   32'h0);
                chk("t2_pcen_stalled", 32'(pc_en), 32'h0);
                chk("t2_valid_held",   32'(valid), 32'h1);
                chk("t2_pc_held",      pc_d,       32'h0);
            end
            adv();
        end
        chk("t2_grants", 32'(ngrant), 32'd2);
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t2_r0_pc",  pc_d,       32'h0);
        chk("t2_r0_req", 32'(req),   32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t2_r1_pc",   pc_d, 32'h4);
        chk("t2_r1_addr", addr, 32'h8);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t2_r2_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t2_r3_valid", 32'(valid), 32'h1);
        chk("t2_r3_pc",    pc_d,       32'h8);
        chk("t2_r3_instr", instr,      tag(32'h8));
        adv();

        // Redirect with one read in flight and one buffered
        do_reset(32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_nocredit", 32'(req), 32'h0);
        adv();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("t3_flush_pcen",  32'(pc_en), 32'h1);
        chk("t3_flush_valid", 32'(valid), 32'h0);
        chk("t3_flush_req",   32'(req),   32'h0);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_c4_valid", 32'(valid), 32'h0);
        chk("t3_c4_addr",  addr,       32'h100);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_c5_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t3_c6_valid", 32'(valid), 32'h1);
        chk("t3_c6_pc",    pc_d,       32'h100);
        chk("t3_c6_instr", instr,      tag(32'h100));
        adv();

        // Redirect coinciding with a response
        do_reset(32'h8);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        chk("t4_flush_pcen",  32'(pc_en), 32'h1);
        chk("t4_flush_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_c3_valid", 32'(valid), 32'h0);
        chk("t4_c3_addr",  addr,       32'h100);
        chk("t4_c3_req",   32'(req),   32'h1);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_c4_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t4_c5_valid", 32'(valid), 32'h1);
        chk("t4_c5_pc",    pc_d,       32'h100);
        chk("t4_c5_instr", instr,      tag(32'h100));
        adv();

        // Back-to-back redirects
        do_reset(32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); adv();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("t4b_f1_pcen", 32'(pc_en), 32'h1);
        adv();
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        chk("t4b_f2_pcen", 32'(pc_en), 32'h1);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4b_c4_addr",  addr,       32'h200);
        chk("t4b_c4_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4b_c5_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t4b_c6_valid", 32'(valid), 32'h1);
        chk("t4b_c6_pc",    pc_d,       32'h200);
        adv();

        // Grant held off for three cycles
        do_reset(32'h20);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("t5_req_c%0d", c),  32'(req),   32'h1);
            chk($sformatf("t5_addr_c%0d", c), addr,       32'h20);
            chk($sformatf("t5_pcen_c%0d", c), 32'(pc_en), 32'h0);
            adv();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_gnt_pcen", 32'(pc_en), 32'h1);
        chk("t5_gnt_addr", addr,       32'h20);
        adv();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_next_addr", addr, 32'h24);
        adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_valid", 32'(valid), 32'h1);
        chk("t5_pc",    pc_d,       32'h20);
        adv();

        // Asynchronous reset mid-stream
        do_reset(32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); adv();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_pre_valid", 32'(valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(valid), 32'h0);
        chk("t6_rst_req",   32'(req),   32'h0);
        chk("t6_rst_pcen",  32'(pc_en), 32'h0);
        chk("t6_rst_pcd",   pc_d,       32'h0);
        chk("t6_rst_instr", instr,      32'h0);
        reqq.delete();
        granted = 1'b0;
        pc      = 32'h40;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_stray_valid", 32'(valid), 32'h0);
        chk("t6_stray_req",   32'(req),   32'h1);
        chk("t6_stray_addr",  addr,       32'h40);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_s1_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t6_s2_valid", 32'(valid), 32'h0);
        adv();
        drive(1'b1, granted, 1'b0, 32'h0, 1'b0);
        chk("t6_s3_valid", 32'(valid), 32'h1);
        chk("t6_s3_pc",    pc_d,       32'h40);
        chk("t6_s3_instr", instr,      tag(32'h40));
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
